// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared async FIFO write port
//
// Purpose:
//   Shares one FIFO write port (winc/wdata/wfull) among NREQ requesters.
//   The owner is picked round robin and holds the port for up to BURST beats.
//   Requesters are back-pressured while wfull is high.
//   Every release passes through one IDLE cycle before the next owner is granted.
//
// Optional feature macro: FIFO_ARB_STATS_EN
//   When defined, this macro adds the stat_beats and stat_stalls counters.
//
// Ports:
//   wclk        write-domain clock
//   wrst_n      asynchronous active-low reset
//   req_valid   per-requester beat pending
//   req_data    per-requester data, requester i at [i*DSIZE +: DSIZE]
//   req_last    per-requester last-beat-of-packet flag
//   req_ready   per-requester accept; a beat transfers when valid & ready
//   wfull       FIFO full flag (wclk domain)
//   winc        FIFO write enable
//   wdata       FIFO write data
//   grant_id    current or most recent owner index
//   busy        high while a grant is active
//   stat_beats  total accepted beats, wraps at 16 bits (stats build only)
//   stat_stalls grant cycles stalled by wfull, wraps at 16 bits (stats build only)

module fifo_wr_arbiter #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int IDXW  = 2,
    parameter int BURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IDXW-1:0]       grant_id,
    output logic                  busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]           stat_beats,
    output logic [15:0]           stat_stalls
`endif
);

    localparam int CNTW = $clog2(BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  owner;
    logic [CNTW-1:0]  beat_cnt;

    logic             owner_valid;
    logic             owner_last;
    logic [IDXW-1:0]  next_owner;
    logic             any_valid;
    logic [IDXW:0]    cand;

    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];
    assign busy        = (state == GRANT);

    // Round-robin pick: scan offsets NREQ down to 1 so the smallest offset
    // from the previous owner is the last match and therefore wins.
    // cand has one spare bit so owner+offset never overflows before the wrap.
    always_comb begin
        next_owner = owner;
        any_valid  = 1'b0;
        cand       = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = {1'b0, owner} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NREQ)) begin
                cand = cand - (IDXW+1)'(NREQ);
            end
            if (req_valid[cand[IDXW-1:0]]) begin
                next_owner = cand[IDXW-1:0];
                any_valid  = 1'b1;
            end
        end
    end

    // The write strobe is combinational so the FIFO captures the beat on the
    // same edge that the requester sees valid & ready. It is also blocked
    // immediately when wfull rises.
    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        if (state == GRANT) begin
            req_ready[owner] = ~wfull;
            winc             = owner_valid & ~wfull;
        end
    end

    assign wdata = req_data[owner*DSIZE +: DSIZE];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            owner    <= IDXW'(NREQ - 1);
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (any_valid) begin
                        owner    <= next_owner;
                        grant_id <= next_owner;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (winc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (owner_last || (beat_cnt == CNTW'(BURST - 1))) begin
                            state <= IDLE;
                        end
                    end else if (!owner_valid) begin
                        // The owner went quiet, even if it is stalled on wfull.
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (winc) begin
                stat_beats <= stat_beats + 16'd1;
            end
            if ((state == GRANT) && owner_valid && wfull) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard testbench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int IDXW  = 2;
    localparam int BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [IDXW-1:0]       grant_id;
    logic                  busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]           stat_beats;
    logic [15:0]           stat_stalls;
`endif

    fifo_wr_arbiter #(
        .DSIZE(DSIZE), .NREQ(NREQ), .IDXW(IDXW), .BURST(BURST)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_beats  (stat_beats),
        .stat_stalls (stat_stalls)
`endif
    );

    always #5 wclk = ~wclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DSIZE:0]           src_mem [NREQ][32];
    int                       head [NREQ];
    int                       tail [NREQ];
    logic [NREQ-1:0]          en;
    logic [IDXW+DSIZE-1:0]    exp_q [$];

    int                       acc_total;
    int                       grants;
    logic                     prev_busy;
    logic                     s_winc;
    logic                     s_busy;
    logic [IDXW-1:0]          s_gid;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (en[i] && head[i] != tail[i]) begin
                req_valid[i] = 1'b1;
                req_last[i]  = src_mem[i][head[i]][DSIZE];
                req_data[i*DSIZE +: DSIZE] = src_mem[i][head[i]][DSIZE-1:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*DSIZE +: DSIZE] = '0;
            end
        end
    endtask

    task automatic load(input int id, input logic [DSIZE-1:0] d, input logic l);
        src_mem[id][tail[id]] = {l, d};
        tail[id]++;
        exp_q.push_back({IDXW'(id), d});
    endtask

    // Sample at negedge, pop the accepted beat after the posedge that took it.
    task automatic step();
        logic [NREQ-1:0]       exp_ready;
        logic                  exp_winc;
        logic                  acc;
        logic [IDXW-1:0]       acc_id;
        logic [IDXW+DSIZE-1:0] e;
        @(negedge wclk);
        exp_ready = (busy && !wfull) ? (NREQ'(1) << grant_id) : '0;
        n_cmp++;
        if (req_ready !== exp_ready) begin
            n_bad++;
            $display("FAIL req_ready: got %b want %b", req_ready, exp_ready);
        end
        exp_winc = busy && !wfull && req_valid[grant_id];
        n_cmp++;
        if (winc !== exp_winc) begin
            n_bad++;
            $display("FAIL winc: got %b want %b", winc, exp_winc);
        end
        s_winc = winc;
        s_busy = busy;
        s_gid  = grant_id;
        if (busy && !prev_busy) grants++;
        prev_busy = busy;
        acc    = 1'b0;
        acc_id = grant_id;
        if (winc === 1'b1) begin
            acc = 1'b1;
            acc_total++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got id %0d data %h want no write", grant_id, wdata);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, wdata} !== e) begin
                    n_bad++;
                    $display("FAIL beat: got id %0d data %h want id %0d data %h",
                             grant_id, wdata, e[IDXW+DSIZE-1:DSIZE], e[DSIZE-1:0]);
                end
            end
        end
        @(posedge wclk);
        #1;
        if (acc && head[acc_id] != tail[acc_id]) head[acc_id]++;
        drive();
    endtask

    task automatic run_until_empty(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            step();
            c++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d beats left want 0", exp_q.size());
        end
    endtask

    task automatic wait_acc(input int target, input int budget);
        int c = 0;
        while (acc_total < target && c < budget) begin
            step();
            c++;
        end
        n_cmp++;
        if (acc_total < target) begin
            n_bad++;
            $display("FAIL wait_acc: got %0d beats want %0d", acc_total, target);
        end
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        wfull  = 1'b0;
        en     = '0;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp_q.delete();
        drive();
        repeat (2) @(posedge wclk);
        #1;
        wrst_n    = 1'b1;
        prev_busy = 1'b0;
        acc_total = 0;
        grants    = 0;
    endtask

    task automatic test_reset();
        do_reset();
        wrst_n = 1'b0;
        en     = '1;
        for (int i = 0; i < NREQ; i++) load(i, DSIZE'(8'h10 + i), 1'b1);
        drive();
        @(negedge wclk);
        n_cmp++;
        if ({busy, winc, req_ready, grant_id} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy %b winc %b ready %b gid %0d want all 0",
                     busy, winc, req_ready, grant_id);
        end
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        run_until_empty(40);
        n_cmp++;
        if (grants !== 4) begin
            n_bad++;
            $display("FAIL reset_grants: got %0d want 4", grants);
        end
    endtask

    task automatic test_burst();
        logic [8:0] log_bits = '0;
        do_reset();
        en[0] = 1'b1;
        for (int k = 0; k < 6; k++) load(0, DSIZE'(8'hA0 + k), k == 5);
        drive();
        for (int k = 0; k < 9; k++) begin
            step();
            log_bits = {log_bits[7:0], s_winc};
        end
        n_cmp++;
        if (log_bits !== 9'b011110110) begin
            n_bad++;
            $display("FAIL burst_pattern: got %b want 011110110", log_bits);
        end
        run_until_empty(4);
    endtask

    task automatic test_round_robin();
        do_reset();
        en = '1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) load(i, DSIZE'(8'h40 + r * 16 + i), 1'b1);
        drive();
        run_until_empty(60);
        n_cmp++;
        if (grants !== 8 || acc_total !== 8) begin
            n_bad++;
            $display("FAIL rr_grants: got %0d grants %0d beats want 8 and 8", grants, acc_total);
        end
    endtask

    task automatic test_stall();
        logic [3:0] log_bits = '0;
        do_reset();
        en[2] = 1'b1;
        for (int k = 0; k < 5; k++) load(2, DSIZE'(8'hC0 + k), k == 4);
        drive();
        wait_acc(2, 10);
        wfull = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (s_busy !== 1'b1 || s_gid !== 2'd2 || s_winc !== 1'b0) begin
                n_bad++;
                $display("FAIL stall: got busy %b gid %0d winc %b want 1 2 0", s_busy, s_gid, s_winc);
            end
        end
        wfull = 1'b0;
        drive();
        for (int k = 0; k < 4; k++) begin
            step();
            log_bits = {log_bits[2:0], s_winc};
        end
        n_cmp++;
        if (log_bits !== 4'b1101) begin
            n_bad++;
            $display("FAIL stall_resume: got %b want 1101", log_bits);
        end
        run_until_empty(4);
`ifdef FIFO_ARB_STATS_EN
        n_cmp++;
        if (stat_stalls !== 16'd5 || stat_beats !== 16'd5) begin
            n_bad++;
            $display("FAIL stats: got stalls %0d beats %0d want 5 5", stat_stalls, stat_beats);
        end
`endif
    endtask

    task automatic test_drop();
        do_reset();
        en[1] = 1'b1;
        en[3] = 1'b1;
        load(1, 8'hD0, 1'b0);
        load(1, 8'hD1, 1'b0);
        load(3, 8'hE0, 1'b1);
        load(1, 8'hD2, 1'b0);
        load(1, 8'hD3, 1'b1);
        drive();
        wait_acc(2, 10);
        en[1] = 1'b0;
        drive();
        step();
        n_cmp++;
        if (s_busy !== 1'b1 || s_winc !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_cycle: got busy %b winc %b want 1 0", s_busy, s_winc);
        end
        step();
        n_cmp++;
        if (s_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_idle: got busy %b want 0", s_busy);
        end
        step();
        n_cmp++;
        if (s_busy !== 1'b1 || s_gid !== 2'd3) begin
            n_bad++;
            $display("FAIL drop_next: got busy %b gid %0d want 1 3", s_busy, s_gid);
        end
        wait_acc(3, 10);
        en[1] = 1'b1;
        drive();
        run_until_empty(20);
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = '1;
        for (int k = 0; k < 4; k++) load(2, DSIZE'(8'hF0 + k), 1'b0);
        drive();
        wait_acc(1, 10);
        wrst_n = 1'b0;
        #1;
        n_cmp++;
        if (winc !== 1'b0 || req_ready !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got winc %b ready %b busy %b want 0 0 0", winc, req_ready, busy);
        end
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp_q.delete();
        load(0, 8'h5A, 1'b1);
        load(3, 8'h5B, 1'b1);
        drive();
        step();
        step();
        wrst_n = 1'b1;
        run_until_empty(20);
    endtask

    initial begin
        wrst_n    = 1'b0;
        wfull     = 1'b0;
        en        = '0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        prev_busy = 1'b0;
        acc_total = 0;
        grants    = 0;
        test_reset();
        test_burst();
        test_round_robin();
        test_stall();
        test_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
